button_press_detector: RTL and testbench



---
 rtl/button_press_detector_if.sv | 10 +
 rtl/button_press_detector.sv | 145 ++++++++++++++
 tb/tb_button_press_detector.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/button_press_detector_if.sv
// Push-button pin and debounced outputs of button_press_detector.
interface button_press_detector_if;
    logic btn_i;
    logic btn_state_o;
    logic btn_was_pressed_o;
    logic btn_was_released_o;

    modport master (output btn_i, input btn_state_o, btn_was_pressed_o, btn_was_released_o);
    modport slave  (input btn_i, output btn_state_o, btn_was_pressed_o, btn_was_released_o);
endinterface

// File: rtl/button_press_detector.sv
// Synchronise, debounce and edge-detect a raw push-button; one-cycle press/release strobes.
// Optional auto-repeat while held: define BUTTON_PRESS_DETECTOR_AUTOREPEAT_EN.
module button_press_detector #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int SYNC_STAGES     = 2,
    parameter bit BTN_ACTIVE_LOW  = 1'b0,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input logic                     clk_i,
    input logic                     rstn_i,
    button_press_detector_if.slave  bus
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] D_LAST = CW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || SYNC_STAGES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
        $error("button_press_detector: illegal parameter value");
    end

    typedef enum logic [1:0] {RELEASED, PRESS_CHECK, PRESSED, RELEASE_CHECK} state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   press_d, release_d, press_any;
    logic                   btn_state_q, press_q, release_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) sync_q <= '0;
        else         sync_q <= {sync_q[SYNC_STAGES-2:0], bus.btn_i ^ BTN_ACTIVE_LOW};
    end
    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= RELEASED;
            cnt_q       <= '0;
            btn_state_q <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            btn_state_q <= (state_d == PRESSED) || (state_d == RELEASE_CHECK);
            press_q     <= press_any;
            release_q   <= release_d;
        end
    end

    // cnt already includes the sample that entered the CHECK state.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            RELEASED: if (s) begin
                state_d = PRESS_CHECK;
                cnt_d   = CW'(1);
            end
            PRESS_CHECK: begin
                if (!s) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == D_LAST) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PRESSED: if (!s) begin
                state_d = RELEASE_CHECK;
                cnt_d   = CW'(1);
            end
            RELEASE_CHECK: begin
                if (s) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == D_LAST) begin
                    state_d   = RELEASED;
                    cnt_d     = '0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = RELEASED;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef BUTTON_PRESS_DETECTOR_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);
    localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0] rcnt_q, rcnt_d;
    logic          rep_on_q, rep_on_d;
    logic          rep_fire;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rcnt_q   <= '0;
            rep_on_q <= 1'b0;
        end else begin
            rcnt_q   <= rcnt_d;
            rep_on_q <= rep_on_d;
        end
    end

    // Counts only while held in PRESSED; RELEASE_CHECK leaves it frozen.
    always_comb begin
        rcnt_d   = rcnt_q;
        rep_on_d = rep_on_q;
        rep_fire = 1'b0;
        if (state_q == RELEASED || (state_q == PRESS_CHECK && state_d == PRESSED)) begin
            rcnt_d   = '0;
            rep_on_d = 1'b0;
        end else if (state_q == PRESSED && state_d == PRESSED) begin
            if ((!rep_on_q && rcnt_q == RD_LAST) || (rep_on_q && rcnt_q == RP_LAST)) begin
                rep_fire = 1'b1;
                rcnt_d   = '0;
                rep_on_d = 1'b1;
            end else begin
                rcnt_d = rcnt_q + 1'b1;
            end
        end
    end

    assign press_any = press_d | rep_fire;
`else
    assign press_any = press_d;
`endif

    assign bus.btn_state_o        = btn_state_q;
    assign bus.btn_was_pressed_o  = press_q;
    assign bus.btn_was_released_o = release_q;
endmodule

// File: tb/tb_button_press_detector.sv
// Random and directed bench for button_press_detector; an active-high and an active-low copy share one stimulus.
module tb_button_press_detector;
    localparam int D  = 4;
    localparam int S  = 2;
    localparam int RD = 20;
    localparam int RP = 8;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic btn = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    button_press_detector_if ifa ();
    button_press_detector_if ifb ();
    assign ifa.btn_i = btn;
    assign ifb.btn_i = ~btn;

    button_press_detector #(.DEBOUNCE_CYCLES(D), .SYNC_STAGES(S), .BTN_ACTIVE_LOW(1'b0),
                            .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP))
        u_hi (.clk_i(clk), .rstn_i(rstn), .bus(ifa));
    button_press_detector #(.DEBOUNCE_CYCLES(D), .SYNC_STAGES(S), .BTN_ACTIVE_LOW(1'b1),
                            .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP))
        u_lo (.clk_i(clk), .rstn_i(rstn), .bus(ifb));

    always #5 clk = ~clk;

    // Reference: level flips after D consecutive synchronised samples disagreeing with it.
    bit sm [S];
    bit lvl, e_press, e_rel, s_old;
    int run, hold;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < S; i++) sm[i] = 1'b0;
            lvl = 0; e_press = 0; e_rel = 0; run = 0; hold = 0;
        end else begin
            s_old   = sm[S-1];
            e_press = 0;
            e_rel   = 0;
            if (s_old != lvl) begin
                run++;
                if (run == D) begin
                    lvl = s_old;
                    run = 0;
                    if (lvl) begin
                        e_press = 1;
                        hold    = 0;
                    end else begin
                        e_rel = 1;
                    end
                end
            end else begin
`ifdef BUTTON_PRESS_DETECTOR_AUTOREPEAT_EN
                if (lvl && run == 0) begin
                    hold++;
                    if (hold == RD || (hold > RD && (hold - RD) % RP == 0)) e_press = 1;
                end
`endif
                run = 0;
            end
            for (int i = S-1; i > 0; i--) sm[i] = sm[i-1];
            sm[0] = btn;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    int n_press = 0;
    int n_rel = 0;

    task automatic cmp_all();
        chk("hi_state", 32'(ifa.btn_state_o), 32'(lvl));
        chk("hi_press", 32'(ifa.btn_was_pressed_o), 32'(e_press));
        chk("hi_rel",   32'(ifa.btn_was_released_o), 32'(e_rel));
        chk("lo_state", 32'(ifb.btn_state_o), 32'(lvl));
        chk("lo_press", 32'(ifb.btn_was_pressed_o), 32'(e_press));
        chk("lo_rel",   32'(ifb.btn_was_released_o), 32'(e_rel));
        if (ifa.btn_was_pressed_o) n_press++;
        if (ifa.btn_was_released_o) n_rel++;
    endtask

    task automatic step(input logic v);
        @(negedge clk);
        cmp_all();
        btn = v;
    endtask

    task automatic hold_lvl(input logic v, input int n);
        for (int i = 0; i < n; i++) step(v);
    endtask

    // Cycles from the first edge sampling a 1 until the press strobe is seen.
    task automatic press_latency(output int lat);
        lat = 0;
        while (lat < 20) begin
            step(1'b1);
            lat++;
            if (ifa.btn_was_pressed_o) break;
        end
    endtask

    task automatic chk_reset_outs();
        chk("rst_state", 32'({ifa.btn_state_o, ifb.btn_state_o}), 32'd0);
        chk("rst_press", 32'({ifa.btn_was_pressed_o, ifb.btn_was_pressed_o}), 32'd0);
        chk("rst_rel",   32'({ifa.btn_was_released_o, ifb.btn_was_released_o}), 32'd0);
    endtask

    int lat;

    initial begin
        hold_lvl(1'b0, 3);
        chk_reset_outs();
        #2 rstn = 1'b1;
        hold_lvl(1'b0, 6);

        // Clean press
        n_press = 0; n_rel = 0;
        step(1'b1);
        press_latency(lat);
        chk("press_latency", 32'(lat), 32'(S + D));
        chk("press_state", 32'(ifa.btn_state_o), 32'd1);
        step(1'b1);
        chk("press_one_cycle", 32'(ifa.btn_was_pressed_o), 32'd0);
        hold_lvl(1'b1, 6);
        chk("clean_press_cnt", 32'(n_press), 32'd1);
        chk("clean_no_rel", 32'(n_rel), 32'd0);

        // Release with bounce
        n_press = 0; n_rel = 0;
        hold_lvl(1'b0, 3);
        hold_lvl(1'b1, 1);
        hold_lvl(1'b0, 10);
        chk("bounce_rel_cnt", 32'(n_rel), 32'd1);
        chk("bounce_rel_state", 32'(ifa.btn_state_o), 32'd0);

        // Bounce rejection, then a real press
        n_press = 0; n_rel = 0;
        hold_lvl(1'b1, 2); hold_lvl(1'b0, 1); hold_lvl(1'b1, 2); hold_lvl(1'b0, 8);
        chk("bounce_no_press", 32'(n_press), 32'd0);
        hold_lvl(1'b1, 10);
        chk("bounce_then_press", 32'(n_press), 32'd1);

        // Reset while pressed drops the level immediately
        #2 rstn = 1'b0;
        #1 chk_reset_outs();
        step(1'b0);
        hold_lvl(1'b0, 2);
        #2 rstn = 1'b1;
        hold_lvl(1'b0, 6);

        // Reset mid PRESS_CHECK (cnt=2), then full latency with pin still high
        step(1'b1);
        hold_lvl(1'b1, 4);
        #2 rstn = 1'b0;
        #1 chk_reset_outs();
        hold_lvl(1'b1, 2);
        #2 rstn = 1'b1;
        press_latency(lat);
        chk("post_rst_latency", 32'(lat), 32'(S + D));
        hold_lvl(1'b0, 12);

        // Long hold: auto-repeat only when the feature is built in
        n_press = 0; n_rel = 0;
        hold_lvl(1'b1, 60);
        hold_lvl(1'b0, 12);
`ifdef BUTTON_PRESS_DETECTOR_AUTOREPEAT_EN
        chk("long_hold_press", 32'(n_press), 32'd6);
`else
        chk("long_hold_press", 32'(n_press), 32'd1);
`endif
        chk("long_hold_rel", 32'(n_rel), 32'd1);

        // Random bouncing segments
        for (int k = 0; k < 80; k++) begin
            logic v;
            v = 1'($urandom);
            if ($urandom_range(0, 3) == 0) hold_lvl(v, $urandom_range(D + S, 14));
            else                           hold_lvl(v, $urandom_range(1, D + 1));
            if ($urandom_range(0, 39) == 0) begin
                #2 rstn = 1'b0;
                #1 chk_reset_outs();
                step(btn);
                #2 rstn = 1'b1;
            end
        end
        hold_lvl(1'b0, 12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
